// File: rtl/mmio_uart_pkg.sv
// Shared constants and state types for the memory-mapped UART.
package mmio_uart_pkg;

    localparam logic [1:0] OFF_TXDATA = 2'd0;
    localparam logic [1:0] OFF_RXDATA = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_BAUD   = 2'd3;

    localparam int unsigned ST_TX_FULL    = 0;
    localparam int unsigned ST_TX_EMPTY   = 1;
    localparam int unsigned ST_TX_BUSY    = 2;
    localparam int unsigned ST_RX_VALID   = 3;
    localparam int unsigned ST_RX_OVERRUN = 4;
    localparam int unsigned ST_FRAME_ERR  = 5;
    localparam int unsigned ST_TX_OVF     = 6;

    localparam logic [15:0] DIV_MIN = 16'd4;

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < DIV_MIN) ? DIV_MIN : v;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter; a push into a full FIFO
// is still accepted when a pop happens on the same edge.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [7:0]  mem_q [DEPTH];
    logic        do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART: TX FIFO + FSM, RX FSM with holding register,
// STATUS and BAUD_DIV registers, combinational read data.
module mmio_uart
    import mmio_uart_pkg::*;
#(
    parameter logic [15:0] BASE     = 16'hC000,
    parameter logic [15:0] DIV_RST  = 16'd434,
    parameter int unsigned TX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        ex_re,
    input  logic        ex_we,
    output logic [15:0] rdata,
    output logic        txd,
    input  logic        rxd,
    output logic        irq
);
    logic       hit, wr_tx, wr_baud, rd_rx, rd_st;
    logic       fifo_full, fifo_empty, fifo_pop, tx_busy;
    logic [7:0] fifo_rdata;

    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;

    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_load, frame_set;

    logic [15:0] baud_q, status;
    logic [7:0]  rx_byte_q;
    logic        rx_valid_q, rx_ovr_q, frame_err_q, tx_ovf_q;

    assign hit     = (addr[15:2] == BASE[15:2]);
    assign wr_tx   = ex_we & hit & (addr[1:0] == OFF_TXDATA);
    assign wr_baud = ex_we & hit & (addr[1:0] == OFF_BAUD);
    assign rd_rx   = ex_re & hit & (addr[1:0] == OFF_RXDATA);
    assign rd_st   = ex_re & hit & (addr[1:0] == OFF_STATUS);

    uart_tx_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_tx),
        .wdata (wdata[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TxIdle;  tx_cnt_q <= '0; tx_div_q <= '0;
            tx_bit_q   <= '0;      tx_shift_q <= '0;
            rx_state_q <= RxIdle;  rx_cnt_q <= '0; rx_div_q <= '0;
            rx_bit_q   <= '0;      rx_shift_q <= '0;
            rx_s1_q    <= 1'b1;    rx_s2_q <= 1'b1; rx_prev_q <= 1'b1;
            baud_q     <= DIV_RST; rx_byte_q <= '0; rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;    frame_err_q <= 1'b0; tx_ovf_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d; tx_cnt_q <= tx_cnt_d; tx_div_q <= tx_div_d;
            tx_bit_q   <= tx_bit_d;   tx_shift_q <= tx_shift_d;
            rx_state_q <= rx_state_d; rx_cnt_q <= rx_cnt_d; rx_div_q <= rx_div_d;
            rx_bit_q   <= rx_bit_d;   rx_shift_q <= rx_shift_d;
            rx_s1_q    <= rxd;        rx_s2_q <= rx_s1_q;   rx_prev_q <= rx_s2_q;
            if (wr_baud) baud_q <= clamp_div(wdata);
            if (rx_load) rx_byte_q <= rx_shift_q;
            rx_valid_q  <= rx_load | (rx_valid_q & ~rd_rx);
            // Set wins over the read-clear of the sticky bits.
            rx_ovr_q    <= (rx_load & rx_valid_q & ~rd_rx) | (rx_ovr_q & ~rd_st);
            frame_err_q <= frame_set | (frame_err_q & ~rd_st);
            tx_ovf_q    <= (wr_tx & fifo_full & ~fifo_pop) | (tx_ovf_q & ~rd_st);
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        unique case (tx_state_q)
            TxIdle: if (!fifo_empty) begin
                tx_state_d = TxStart;
                tx_shift_d = fifo_rdata;
                tx_div_d   = baud_q;
                tx_cnt_d   = baud_q - 16'd1;
            end
            TxStart: if (tx_cnt_q == '0) begin
                tx_state_d = TxData;
                tx_cnt_d   = tx_div_q - 16'd1;
                tx_bit_d   = '0;
            end else tx_cnt_d = tx_cnt_q - 16'd1;
            TxData: if (tx_cnt_q == '0) begin
                tx_cnt_d   = tx_div_q - 16'd1;
                tx_shift_d = tx_shift_q >> 1;
                if (tx_bit_q == 3'd7) tx_state_d = TxStop;
                else                  tx_bit_d   = tx_bit_q + 3'd1;
            end else tx_cnt_d = tx_cnt_q - 16'd1;
            TxStop: if (tx_cnt_q == '0) tx_state_d = TxIdle;
                    else                tx_cnt_d   = tx_cnt_q - 16'd1;
            default: tx_state_d = TxIdle;
        endcase
    end

    always_comb begin
        fifo_pop = (tx_state_q == TxIdle) & ~fifo_empty;
        tx_busy  = (tx_state_q != TxIdle);
        unique case (tx_state_q)
            TxStart: txd = 1'b0;
            TxData:  txd = tx_shift_q[0];
            default: txd = 1'b1;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_div_d   = rx_div_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        unique case (rx_state_q)
            RxIdle: if (rx_prev_q & ~rx_s2_q) begin
                rx_state_d = RxStart;
                rx_div_d   = baud_q;
                rx_cnt_d   = (baud_q >> 1) - 16'd1;
            end
            RxStart: if (rx_cnt_q == '0) begin
                if (rx_s2_q) rx_state_d = RxIdle;
                else begin
                    rx_state_d = RxData;
                    rx_cnt_d   = rx_div_q - 16'd1;
                    rx_bit_d   = '0;
                end
            end else rx_cnt_d = rx_cnt_q - 16'd1;
            RxData: if (rx_cnt_q == '0) begin
                rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                rx_cnt_d   = rx_div_q - 16'd1;
                if (rx_bit_q == 3'd7) rx_state_d = RxStop;
                else                  rx_bit_d   = rx_bit_q + 3'd1;
            end else rx_cnt_d = rx_cnt_q - 16'd1;
            RxStop: if (rx_cnt_q == '0) rx_state_d = RxIdle;
                    else                rx_cnt_d   = rx_cnt_q - 16'd1;
            default: rx_state_d = RxIdle;
        endcase
    end

    always_comb begin
        rx_load   = (rx_state_q == RxStop) && (rx_cnt_q == '0) && rx_s2_q;
        frame_set = (rx_state_q == RxStop) && (rx_cnt_q == '0) && !rx_s2_q;
    end

    always_comb begin
        status                = '0;
        status[ST_TX_FULL]    = fifo_full;
        status[ST_TX_EMPTY]   = fifo_empty;
        status[ST_TX_BUSY]    = tx_busy;
        status[ST_RX_VALID]   = rx_valid_q;
        status[ST_RX_OVERRUN] = rx_ovr_q;
        status[ST_FRAME_ERR]  = frame_err_q;
        status[ST_TX_OVF]     = tx_ovf_q;
        rdata = '0;
        if (ex_re && hit) begin
            case (addr[1:0])
                OFF_RXDATA: rdata = {8'h00, rx_byte_q};
                OFF_STATUS: rdata = status;
                OFF_BAUD:   rdata = baud_q;
                default:    rdata = '0;
            endcase
        end
    end

    assign irq = rx_valid_q | (fifo_empty & ~tx_busy);

endmodule

// File: tb/tb_mmio_uart.sv
// Directed self-checking bench for mmio_uart at BAUD_DIV=8.
module tb_mmio_uart;
    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] addr  = '0;
    logic [15:0] wdata = '0;
    logic        ex_re = 1'b0;
    logic        ex_we = 1'b0;
    logic [15:0] rdata;
    logic        txd;
    logic        rxd   = 1'b1;
    logic        irq;
    int checks   = 0;
    int failures = 0;

    mmio_uart dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .wdata (wdata),
        .ex_re (ex_re),
        .ex_we (ex_we),
        .rdata (rdata),
        .txd   (txd),
        .rxd   (rxd),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        addr = a; wdata = d; ex_we = 1'b1;
        @(posedge clk); #1;
        ex_we = 1'b0; addr = '0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        addr = a; ex_re = 1'b1;
        #2 d = rdata;
        @(posedge clk); #1;
        ex_re = 1'b0; addr = '0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = f[i];
            repeat (8) @(posedge clk);
            #1;
        end
        rxd = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [15:0] d;
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (txd !== 1'b1 || irq !== 1'b1 || rdata !== 16'h0000) begin
            failures++;
            $display("FAIL reset_outputs got txd=%b irq=%b rdata=%h want 1 1 0000",
                     txd, irq, rdata);
        end
        rst_n = 1'b1;
        bus_read(16'hC002, d);
        checks++;
        if (d !== 16'h0002) begin
            failures++; $display("FAIL reset_status got %h want 0002", d);
        end
        bus_read(16'hC004, d);
        checks++;
        if (d !== 16'h0000) begin
            failures++; $display("FAIL unmapped_read got %h want 0000", d);
        end
        bus_read(16'hC003, d);
        checks++;
        if (d !== 16'h01B2) begin
            failures++; $display("FAIL reset_baud got %h want 01b2", d);
        end
    endtask

    task automatic test_baud;
        logic [15:0] d;
        bus_write(16'hC003, 16'd2);
        bus_read(16'hC003, d);
        checks++;
        if (d !== 16'h0004) begin
            failures++; $display("FAIL baud_clamp got %h want 0004", d);
        end
        bus_write(16'hC003, 16'd5);
        bus_read(16'hC003, d);
        checks++;
        if (d !== 16'h0005) begin
            failures++; $display("FAIL baud_five got %h want 0005", d);
        end
        bus_write(16'hC003, 16'd8);
        bus_read(16'hC003, d);
        checks++;
        if (d !== 16'h0008) begin
            failures++; $display("FAIL baud_eight got %h want 0008", d);
        end
    endtask

    task automatic test_tx_frame;
        logic [9:0] frame;
        logic       found;
        frame = {1'b1, 8'hA5, 1'b0};
        found = 1'b0;
        bus_write(16'hC000, 16'h00A5);
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            if (txd === 1'b0) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL tx_start got txd=%b want 0 within 20 clocks", txd);
        end else begin
            for (int c = 0; c < 80; c++) begin
                if (c > 0) begin @(posedge clk); #1; end
                checks++;
                if (txd !== frame[c/8] || irq !== 1'b0) begin
                    failures++;
                    $display("FAIL tx_frame cycle %0d got txd=%b irq=%b want txd=%b irq=0",
                             c, txd, irq, frame[c/8]);
                end
            end
            @(posedge clk); #1;
            checks++;
            if (irq !== 1'b1 || txd !== 1'b1) begin
                failures++; $display("FAIL tx_done got irq=%b txd=%b want 1 1", irq, txd);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] d;
        logic        done;
        bus_write(16'hC000, 16'h0011);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) bus_write(16'hC000, 16'h0021 + 16'(i));
        bus_read(16'hC002, d);
        checks++;
        if (d !== 16'h0045) begin
            failures++; $display("FAIL tx_ovf_set got %h want 0045", d);
        end
        bus_read(16'hC002, d);
        checks++;
        if (d !== 16'h0005) begin
            failures++; $display("FAIL tx_ovf_clear got %h want 0005", d);
        end
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(posedge clk); #1;
            if (irq === 1'b1) done = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++; $display("FAIL tx_drain got irq=%b want 1 within 2000 clocks", irq);
        end
    endtask

    task automatic test_rx;
        logic [15:0] d;
        send_rx(8'h3C, 1'b1);
        checks++;
        if (irq !== 1'b1) begin
            failures++; $display("FAIL rx_irq got %b want 1", irq);
        end
        bus_read(16'hC002, d);
        checks++;
        if (d !== 16'h000A) begin
            failures++; $display("FAIL rx_valid_status got %h want 000a", d);
        end
        bus_read(16'hC001, d);
        checks++;
        if (d !== 16'h003C) begin
            failures++; $display("FAIL rx_data got %h want 003c", d);
        end
        bus_read(16'hC002, d);
        checks++;
        if (d !== 16'h0002) begin
            failures++; $display("FAIL rx_valid_clear got %h want 0002", d);
        end
        send_rx(8'h5A, 1'b1);
        send_rx(8'hC3, 1'b1);
        bus_read(16'hC002, d);
        checks++;
        if (d !== 16'h001A) begin
            failures++; $display("FAIL rx_overrun got %h want 001a", d);
        end
        bus_read(16'hC001, d);
        checks++;
        if (d !== 16'h00C3) begin
            failures++; $display("FAIL rx_overwrite got %h want 00c3", d);
        end
    endtask

    task automatic test_rx_errors;
        logic [15:0] d;
        send_rx(8'h77, 1'b0);
        bus_read(16'hC002, d);
        checks++;
        if (d !== 16'h0022) begin
            failures++; $display("FAIL frame_err got %h want 0022", d);
        end
        bus_read(16'hC002, d);
        checks++;
        if (d !== 16'h0002) begin
            failures++; $display("FAIL frame_err_clear got %h want 0002", d);
        end
        rxd = 1'b0;
        repeat (2) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (120) @(posedge clk);
        #1;
        bus_read(16'hC002, d);
        checks++;
        if (d !== 16'h0002) begin
            failures++; $display("FAIL rx_glitch got %h want 0002", d);
        end
        bus_read(16'hC001, d);
        checks++;
        if (d !== 16'h00C3) begin
            failures++; $display("FAIL rx_glitch_byte got %h want 00c3", d);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [15:0] d;
        logic        found;
        logic        saw_low;
        found = 1'b0;
        bus_write(16'hC000, 16'h0000);
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #1;
            if (txd === 1'b0) found = 1'b1;
        end
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (!found || txd !== 1'b1) begin
            failures++;
            $display("FAIL reset_async_txd got txd=%b started=%b want 1 1", txd, found);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus_read(16'hC002, d);
        checks++;
        if (d !== 16'h0002) begin
            failures++; $display("FAIL reset_fifo_empty got %h want 0002", d);
        end
        bus_read(16'hC003, d);
        checks++;
        if (d !== 16'h01B2) begin
            failures++; $display("FAIL reset_baud_restore got %h want 01b2", d);
        end
        saw_low = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (txd !== 1'b1) saw_low = 1'b1;
        end
        checks++;
        if (saw_low) begin
            failures++; $display("FAIL reset_no_tx got txd low after reset want idle high");
        end
    endtask

    initial begin
        test_reset();
        test_baud();
        test_tx_frame();
        test_back_to_back();
        test_rx();
        test_rx_errors();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmio_uart.md
Name: mmio_uart

Overview:
- Memory-mapped serial peripheral that acts as the responder on the CPU's external data-memory bus (addr, wdata, rdata, ex_re, ex_we).
- The CPU asserts ex_re/ex_we only for addresses with addr[15:13] != 0; this block decodes a 4-word window inside that space.
- Provides 8N1 UART transmit (4-entry FIFO) and receive (single holding register), plus status and baud-divisor registers.
- rdata is combinational in the same cycle as ex_re, because the CPU captures it in that cycle.

Parameters:
- BASE, 16'hC000, window base address; bits [1:0] must be 0.
- DIV_RST, 16'd434, reset value of BAUD_DIV (clocks per bit).
- TX_DEPTH, 4, TX FIFO entries; power of 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- addr  in  16  CPU external address
- wdata  in  16  CPU store data
- ex_re  in  1  external read strobe, one cycle per load
- ex_we  in  1  external write strobe, one cycle per store
- rdata  out  16  read data, combinational
- txd  out  1  serial output, idle high
- rxd  in  1  serial input, asynchronous
- irq  out  1  level: rx_valid | (tx_empty & ~tx_busy)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Decode: hit = (addr[15:2] == BASE[15:2]). Offsets: 0 TXDATA (W), 1 RXDATA (R), 2 STATUS (R), 3 BAUD_DIV (R/W).
- rdata = 16'h0000 when ~(ex_re & hit), so peripheral outputs can be OR-combined. Write-only and unmapped reads also return 0.
- Writes take effect on the clk edge where ex_we & hit. Read side effects also occur on the edge where ex_re & hit.
- TXDATA write: wdata[7:0] is pushed into the TX FIFO. If the FIFO is full, the byte is dropped and sticky tx_ovf is set.
- RXDATA read: rdata = {8'h00, rx_byte}; rx_valid clears on the edge.
- STATUS layout:
  - [0] tx_full
  - [1] tx_empty
  - [2] tx_busy
  - [3] rx_valid
  - [4] rx_overrun
  - [5] frame_err
  - [6] tx_ovf
  - other bits 0
  - Reading STATUS clears bits [6:4] on the edge.
- BAUD_DIV write: stored value = max(wdata, 16'd4).
  - TX latches the divisor at each frame start; RX latches it at each start-bit detection.
  - A write mid-frame therefore never alters a frame in flight.
- TX FSM:
  - IDLE: txd=1; if FIFO non-empty, pop and go to START.
  - START: txd=0 for div clocks.
  - DATA: bits LSB first, div clocks each, 3-bit bit counter.
  - STOP: txd=1 for div clocks, then IDLE. Back-to-back frames go IDLE->START in 1 cycle.
  - tx_busy = (state != IDLE).
- RX path:
  - rxd passes through a 2-flop synchroniser.
  - FSM: IDLE waits for a falling edge. START samples at div/2; if high, it is a glitch and returns to IDLE.
  - DATA samples at each full div after mid-start.
  - STOP samples once. If low, set frame_err and discard the byte. If high, load rx_byte and set rx_valid.
  - If rx_valid is already 1 at load time, overwrite rx_byte and set rx_overrun.
- Simultaneous events:
  - RXDATA read on the same edge a new byte loads: rdata shows the old byte; the new byte loads; rx_valid stays 1; no overrun.
  - TXDATA push with FIFO full on the same edge the TX FSM pops: the push is accepted and tx_ovf is not set.
  - STATUS read on the same edge a sticky bit sets: the set wins.
- Reset values:
  - txd=1, irq=1 (TX empty and idle), rdata=0.
  - FIFO empty, pointers 0, both FSMs IDLE.
  - BAUD_DIV=DIV_RST; rx_byte=0; all flags 0; synchroniser flops=1.
  - Reset mid-frame aborts immediately with txd=1.
- Width rules: baud counter 16 bits, counts div-1 down to 0. FIFO pointers are log2(TX_DEPTH)+1 bits; full/empty are derived from the MSB compare.

Decomposition:
- Shared package holds:
  - register offset constants OFF_TXDATA, OFF_RXDATA, OFF_STATUS, OFF_BAUD
  - STATUS bit-index constants
  - TX/RX state enums
  - DIV_MIN = 4
- Natural sub-module: uart_tx_fifo (sync FIFO, push/pop/full/empty). The RX and TX FSMs stay in mmio_uart.

Test Plan:
- Reset, then read STATUS at 16'hC002 -> rdata=16'h0002. txd=1, irq=1. Read at 16'hC004 -> 16'h0000.
- BAUD_DIV=8; write 16'h00A5 to C000 -> txd low 8 clks, then bits 1,0,1,0,0,1,0,1 at 8 clks each, then high 8 clks. tx_busy=1 throughout the frame.
- Five TXDATA writes back-to-back while the first frame is active -> the fifth is dropped and STATUS[6]=1. A STATUS read clears it; the next STATUS read returns [6]=0.
- BAUD_DIV=8; drive an rxd frame of 0x3C -> rx_valid=1 and irq=1. Read C001 -> 16'h003C, then STATUS[3]=0. A second frame unread followed by a third -> STATUS[4]=1 and rx_byte holds the third byte.
- rxd frame with stop bit low -> STATUS[5]=1 and rx_valid stays 0. A 2-clock low glitch on rxd -> no state change.
- Write BAUD_DIV=2 -> reads back 16'h0004. Assert rst_n low mid-TX frame -> txd=1 asynchronously; after release, FIFO empty and BAUD_DIV=434.
